// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: host controller states, digest geometry,
// word type, round constants and initial hash values.
package sha256_pkg;

  localparam int DIGEST_WORDS = 8;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_KICK,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_FETCH,
    ST_SEND
  } host_state_t;

  localparam word_t H_INIT [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/sha256_host_ctrl.sv
// Host-side front end for the SHA-256 engine: streams the message into shared
// memory, kicks the engine, waits for it, then streams the digest back out.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_LOAD      | accept message words, write them at message_addr+wcnt
// ST_KICK      | one-cycle sha_start, hand memory to the engine
// ST_WAIT_LOW  | wait for the engine to leave idle (done low)
// ST_WAIT_HIGH | wait for the engine to finish (done high again)
// ST_FETCH     | 9 cycles: read 8 digest words, data lags address by one
// ST_SEND      | present dig[scnt] on the digest stream, h0 first
module sha256_host_ctrl
  import sha256_pkg::*;
#(
  parameter int NUM_OF_WORDS   = 20,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        sha_start,
  input  logic        sha_done,
  output logic        mem_owner,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        digest_valid,
  input  logic        digest_ready,
  output logic [31:0] digest_data,
  output logic        digest_last,
  output logic        busy,
  output logic        timeout
);

  localparam logic [15:0] LAST_WORD = 16'(NUM_OF_WORDS - 1);
  localparam logic [31:0] TO_LIMIT  = 32'(TIMEOUT_CYCLES);

  host_state_t state, state_nxt;
  logic [15:0] wcnt, wcnt_nxt;
  logic [3:0]  rcnt, rcnt_nxt;
  logic [2:0]  scnt, scnt_nxt;
  logic [31:0] tcnt, tcnt_nxt, tcnt_inc;
  logic        timeout_q, timeout_nxt;
  logic        in_hs, dig_hs;
  word_t       dig [DIGEST_WORDS];

  assign in_hs    = (state == ST_LOAD) && in_valid;
  assign dig_hs   = (state == ST_SEND) && digest_ready;
  assign tcnt_inc = tcnt + 32'd1;

  // State, counters and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_LOAD;
      wcnt      <= '0;
      rcnt      <= '0;
      scnt      <= '0;
      tcnt      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      wcnt      <= wcnt_nxt;
      rcnt      <= rcnt_nxt;
      scnt      <= scnt_nxt;
      tcnt      <= tcnt_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  // Digest capture; read data for address rcnt arrives while rcnt+1 is on the bus.
  always_ff @(posedge clk) begin
    if ((state == ST_FETCH) && (rcnt != 4'd0)) begin
      dig[3'(rcnt - 4'd1)] <= mem_read_data;
    end
  end

  // Next-state logic and memory/stream port decode.
  always_comb begin
    state_nxt      = state;
    wcnt_nxt       = wcnt;
    rcnt_nxt       = rcnt;
    scnt_nxt       = scnt;
    tcnt_nxt       = tcnt;
    timeout_nxt    = timeout_q;
    in_ready       = 1'b0;
    sha_start      = 1'b0;
    mem_owner      = 1'b1;
    mem_we         = 1'b0;
    mem_addr       = message_addr + wcnt;
    mem_write_data = in_data;
    digest_valid   = 1'b0;
    digest_data    = dig[scnt];
    digest_last    = 1'b0;

    unique case (state)
      ST_LOAD: begin
        in_ready = 1'b1;
        mem_we   = in_valid;
        if (in_hs) begin
          timeout_nxt = 1'b0;
          if (wcnt == LAST_WORD) begin
            wcnt_nxt  = '0;
            state_nxt = ST_KICK;
          end else begin
            wcnt_nxt = wcnt + 16'd1;
          end
        end
      end
      ST_KICK: begin
        sha_start = 1'b1;
        mem_owner = 1'b0;
        tcnt_nxt  = '0;
        state_nxt = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        // done is still high right after the kick, so only a low level counts here
        mem_owner = 1'b0;
        tcnt_nxt  = tcnt_inc;
        if (tcnt_inc >= TO_LIMIT) begin
          timeout_nxt = 1'b1;
          wcnt_nxt    = '0;
          state_nxt   = ST_LOAD;
        end else if (!sha_done) begin
          state_nxt = ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        mem_owner = 1'b0;
        tcnt_nxt  = tcnt_inc;
        if (tcnt_inc >= TO_LIMIT) begin
          timeout_nxt = 1'b1;
          wcnt_nxt    = '0;
          state_nxt   = ST_LOAD;
        end else if (sha_done) begin
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        mem_addr = output_addr + {12'd0, rcnt};
        if (rcnt == 4'd8) begin
          rcnt_nxt  = '0;
          state_nxt = ST_SEND;
        end else begin
          rcnt_nxt = rcnt + 4'd1;
        end
      end
      ST_SEND: begin
        digest_valid = 1'b1;
        digest_last  = (scnt == 3'd7);
        if (dig_hs) begin
          scnt_nxt = scnt + 3'd1;
          if (scnt == 3'd7) begin
            state_nxt = ST_LOAD;
          end
        end
      end
      default: begin
        state_nxt = ST_LOAD;
      end
    endcase
  end

  assign busy    = !((state == ST_LOAD) && (wcnt == 16'd0));
  assign timeout = timeout_q;

endmodule

// File: tb/tb_sha256_host_ctrl.sv
// Bench for sha256_host_ctrl: stub engine, shared memory model, scoreboard on
// the digest stream, plus a second instance with a short timeout.
module tb_sha256_host_ctrl;
  import sha256_pkg::*;

  localparam int NW     = 20;
  localparam int NW_TO  = 4;
  localparam int TO_TO  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- main instance ----------------
  logic        reset;
  logic [15:0] message_addr, output_addr;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        sha_start, sha_done, mem_owner, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;
  logic        digest_valid, digest_ready, digest_last;
  logic [31:0] digest_data;
  logic        busy, timeout;

  sha256_host_ctrl #(.NUM_OF_WORDS(NW), .TIMEOUT_CYCLES(4096)) dut (
    .clk(clk), .reset(reset), .message_addr(message_addr), .output_addr(output_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sha_start(sha_start), .sha_done(sha_done), .mem_owner(mem_owner),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .digest_valid(digest_valid), .digest_ready(digest_ready), .digest_data(digest_data), .digest_last(digest_last),
    .busy(busy), .timeout(timeout)
  );

  // ---------------- timeout instance ----------------
  logic        to_in_valid, to_in_ready;
  logic [31:0] to_in_data;
  logic        to_sha_start, to_mem_owner, to_mem_we;
  logic [15:0] to_mem_addr;
  logic [31:0] to_mem_write_data;
  logic        to_digest_valid, to_digest_last, to_busy, to_timeout;
  logic [31:0] to_digest_data;
  logic [15:0] to_message_addr, to_output_addr;
  logic        to_done, to_digest_ready;
  logic [31:0] to_mem_read_data;
  assign to_message_addr  = 16'h0200;
  assign to_output_addr   = 16'h0300;
  assign to_done          = 1'b1;
  assign to_digest_ready  = 1'b1;
  assign to_mem_read_data = 32'h0;

  sha256_host_ctrl #(.NUM_OF_WORDS(NW_TO), .TIMEOUT_CYCLES(TO_TO)) dut_to (
    .clk(clk), .reset(reset), .message_addr(to_message_addr), .output_addr(to_output_addr),
    .in_valid(to_in_valid), .in_ready(to_in_ready), .in_data(to_in_data),
    .sha_start(to_sha_start), .sha_done(to_done), .mem_owner(to_mem_owner),
    .mem_we(to_mem_we), .mem_addr(to_mem_addr), .mem_write_data(to_mem_write_data), .mem_read_data(to_mem_read_data),
    .digest_valid(to_digest_valid), .digest_ready(to_digest_ready), .digest_data(to_digest_data), .digest_last(to_digest_last),
    .busy(to_busy), .timeout(to_timeout)
  );

  // ---------------- stub engine ----------------
  int         stub_phase;  // 0 idle, 1 done still high after start, 2 running
  int         stub_cnt, stub_wk;
  int         stub_delay, stub_len;
  logic [7:0] stub_tag;
  logic        stub_we;
  logic [15:0] stub_addr;
  logic [31:0] stub_wdata;

  always @(posedge clk) begin
    if (reset) begin
      stub_phase <= 0; stub_cnt <= 0; stub_wk <= 0;
    end else begin
      case (stub_phase)
        0: if (sha_start) begin
             if (stub_delay <= 1) begin stub_phase <= 2; stub_cnt <= stub_len; stub_wk <= 0; end
             else begin stub_phase <= 1; stub_cnt <= stub_delay - 1; end
           end
        1: if (stub_cnt == 1) begin stub_phase <= 2; stub_cnt <= stub_len; stub_wk <= 0; end
           else stub_cnt <= stub_cnt - 1;
        default: begin
          if (stub_wk < 8) stub_wk <= stub_wk + 1;
          if (stub_cnt == 1) stub_phase <= 0;
          else stub_cnt <= stub_cnt - 1;
        end
      endcase
    end
  end

  assign sha_done   = (stub_phase != 2);
  assign stub_we    = (stub_phase == 2) && (stub_wk < 8);
  assign stub_addr  = output_addr + 16'(stub_wk);
  assign stub_wdata = 32'hA000_0000 + {16'h0, stub_tag, 8'h00} + 32'(stub_wk);

  // ---------------- shared memory ----------------
  logic [31:0] mem [0:65535];
  logic        m_we;
  logic [15:0] m_addr;
  logic [31:0] m_wdata;
  assign m_we    = mem_owner ? mem_we : stub_we;
  assign m_addr  = mem_owner ? mem_addr : stub_addr;
  assign m_wdata = mem_owner ? mem_write_data : stub_wdata;

  always @(posedge clk) begin
    if (m_we) mem[m_addr] <= m_wdata;
    mem_read_data <= mem[m_addr];
  end

  // ---------------- digest ready driver ----------------
  bit rand_mode = 1'b0;
  always @(posedge clk) begin
    #1;
    digest_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  logic [32:0] exp_q [$];
  int acc_total = 0, run_base = 0, last_acc_cyc = -1;
  int start_cnt = 0, last_start_cyc = -1;
  int done_fall_cyc = -1, done_rise_cyc = -1, owner_rise_cyc = -1, first_valid_cyc = -1;
  int hs_cnt = 0;
  logic prev_done = 1'b1, prev_owner = 1'b1, prev_dv = 1'b0, prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [32:0] e;

  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) begin
        check("wr_we", {31'd0, mem_we}, 32'd1);
        check("wr_addr", {16'd0, mem_addr}, {16'd0, 16'(message_addr + 16'(acc_total - run_base))});
        check("wr_data", mem_write_data, in_data);
        acc_total++;
        last_acc_cyc = cyc;
      end
      if (sha_start) begin
        start_cnt++;
        last_start_cyc = cyc;
        check("owner_at_start", {31'd0, mem_owner}, 32'd0);
      end
      if (prev_done && !sha_done) done_fall_cyc = cyc;
      if (!prev_done && sha_done) done_rise_cyc = cyc;
      if (!prev_owner && mem_owner) owner_rise_cyc = cyc;
      if (!prev_dv && digest_valid) first_valid_cyc = cyc;
      if (digest_valid && prev_stall) check("digest_stable", digest_data, prev_data);
      if (digest_valid && digest_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL digest_extra: got 0x%08h, expected no word (cycle %0d)", digest_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("digest_data", digest_data, e[31:0]);
          check("digest_last", {31'd0, digest_last}, {31'd0, e[32]});
        end
        hs_cnt++;
      end
      prev_stall = digest_valid && !digest_ready;
      prev_data  = digest_data;
    end else begin
      prev_stall = 1'b0;
    end
    prev_done  = sha_done;
    prev_owner = mem_owner;
    prev_dv    = digest_valid;
  end

  int to_start_cyc = -1, to_rise_cyc = -1;
  bit to_dv_seen = 1'b0;
  logic to_prev_to = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (to_sha_start) to_start_cyc = cyc;
      if (to_timeout && !to_prev_to) to_rise_cyc = cyc;
      if (to_digest_valid) to_dv_seen = 1'b1;
    end
    to_prev_to = to_timeout;
  end

  // ---------------- stimulus ----------------
  task automatic send_words(input logic [31:0] base, input bit rnd, input int n);
    int i = 0;
    int guard = 0;
    bit hs;
    while (i < n && guard < 2000) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = base + 32'(i);
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
    end
    in_valid = 1'b0;
    check("words_accepted", 32'(i), 32'(n));
  endtask

  task automatic wait_hs(input int target);
    int guard = 0;
    while (hs_cnt < target && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("digest_count", 32'(hs_cnt), 32'(target));
  endtask

  task automatic do_run(input logic [15:0] maddr, input logic [7:0] tag, input bit rnd,
                        input int delay, input int len);
    int s0, h0;
    message_addr = maddr;
    stub_delay   = delay;
    stub_len     = len;
    stub_tag     = tag;
    run_base     = acc_total;
    rand_mode    = rnd;
    s0 = start_cnt;
    h0 = hs_cnt;
    for (int k = 0; k < 8; k++)
      exp_q.push_back({(k == 7), 32'hA000_0000 + {16'h0, tag, 8'h00} + 32'(k)});
    send_words({8'h00, tag, 16'h0000}, rnd, NW);
    wait_hs(h0 + 8);
    rand_mode = 1'b0;
    check("start_pulses", 32'(start_cnt - s0), 32'd1);
    check("start_after_last_word", 32'(last_start_cyc - last_acc_cyc), 32'd1);
    check("done_fall_delay", 32'(done_fall_cyc - last_start_cyc), 32'(delay));
    check("no_fetch_before_done_low", {31'd0, owner_rise_cyc > done_fall_cyc}, 32'd1);
    check("owner_rise_latency", 32'(owner_rise_cyc - done_rise_cyc), 32'd1);
    check("first_valid_latency", 32'(first_valid_cyc - done_rise_cyc), 32'd10);
    for (int i = 0; i < NW; i++)
      check("mem_message", mem[16'(maddr + 16'(i))], {8'h00, tag, 16'(i)});
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int h0, guard;
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    message_addr = 16'h1234; output_addr = 16'h0100;
    stub_delay = 2; stub_len = 100; stub_tag = 8'h00;
    to_in_valid = 1'b0; to_in_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_sha_start", {31'd0, sha_start}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'h0000_1234);
    check("rst_mem_owner", {31'd0, mem_owner}, 32'd1);
    check("rst_digest_valid", {31'd0, digest_valid}, 32'd0);
    check("rst_digest_last", {31'd0, digest_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    message_addr = 16'h0000;
    @(posedge clk); #1;

    do_run(16'h0000, 8'h00, 1'b0, 2, 100);   // nominal
    do_run(16'h0000, 8'h01, 1'b1, 2, 100);   // stream stalls
    do_run(16'h0000, 8'h02, 1'b0, 4, 20);    // done high 3 cycles after start
    do_run(16'hFFFC, 8'h03, 1'b0, 2, 20);    // address wrap

    // mid-SEND reset after three digest words
    message_addr = 16'h0040; stub_delay = 2; stub_len = 20; stub_tag = 8'h04;
    run_base = acc_total;
    h0 = hs_cnt;
    for (int k = 0; k < 3; k++)
      exp_q.push_back({1'b0, 32'hA000_0400 + 32'(k)});
    send_words(32'h0004_0000, 1'b0, NW);
    wait_hs(h0 + 3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_send_valid", {31'd0, digest_valid}, 32'd0);
    check("rst_mid_send_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mid_send_busy", {31'd0, busy}, 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;

    // timeout instance: engine never drops done
    for (int i = 0; i < NW_TO; i++) begin
      to_in_valid = 1'b1; to_in_data = 32'(i);
      @(negedge clk);
      check("to_in_ready", {31'd0, to_in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    to_in_valid = 1'b0;
    guard = 0;
    while (to_rise_cyc < 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("to_flag_set", {31'd0, to_timeout}, 32'd1);
    check("to_latency", 32'(to_rise_cyc - to_start_cyc), 32'(TO_TO + 1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("to_sticky", {31'd0, to_timeout}, 32'd1);
    check("to_back_in_load_busy", {31'd0, to_busy}, 32'd0);
    check("to_back_in_load_owner", {31'd0, to_mem_owner}, 32'd1);
    check("to_no_digest", {31'd0, to_dv_seen}, 32'd0);
    @(posedge clk); #1;
    to_in_valid = 1'b1; to_in_data = 32'h55;
    @(posedge clk); #1;
    to_in_valid = 1'b0;
    @(negedge clk);
    check("to_cleared_by_word", {31'd0, to_timeout}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
